// File: rtl/sha256_pad_feeder.sv
// sha256_pad_feeder
//   Takes a byte stream, appends SHA-256 padding (0x80, zero fill, 64-bit
//   big-endian bit length) and hands the padded message to the hash core as
//   16-bit big-endian halfwords, one load/ack handshake each, 32 per block.
//   After the final block it fetches the 16 digest halfwords and presents
//   the 256-bit digest with a one-cycle valid pulse.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   s_data[7:0]    message byte
//   s_valid        byte valid
//   s_last         final byte of the message (qualified by s_valid)
//   s_ready        byte taken when s_valid & s_ready (registered)
//   load           one-cycle pulse, wdata carries a message halfword
//   fetch          one-cycle pulse, request next digest halfword
//   wdata[15:0]    halfword to the core, stable from load until ack
//   ack            interface acknowledge
//   rdata[15:0]    digest halfword, valid with ack after a fetch
//   core_busy      hash core busy
//   digest[255:0]  final hash, halfword 0 in [255:240]
//   digest_valid   one-cycle pulse when digest is updated
//   idle           high while in IDLE
module sha256_pad_feeder #(
    parameter int LEN_W   = 32,
    parameter int GAP_CYC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic         load,
    output logic         fetch,
    output logic [15:0]  wdata,
    input  logic         ack,
    input  logic [15:0]  rdata,
    input  logic         core_busy,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         idle
);

    localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_WAIT_ACK,
        S_FLUSH,
        S_FETCH,
        S_FETCH_ACK,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [LEN_W-1:0] byte_cnt;
    logic [4:0]       hw_idx;      // halfword index within the block
    logic             sel;         // 0: next byte is the high byte of a pair
    logic [7:0]       hi_byte;
    logic             last_seen;   // s_last accepted, bytes now come from the pad source
    logic             sent80;      // 0x80 marker already emitted
    logic             len_blk;     // this block carries the length field
    logic [GAP_W-1:0] gap;
    logic [3:0]       dig_idx;
    logic [255:0]     shadow;      // digest under assembly, copied out at DONE

    logic        load_next, fetch_next, dv_next, ready_next, last_next;
    logic        accept, got_byte, issue_go, flush_go, fetch_go;
    logic        ack_load, ack_fetch, final_blk;
    logic [5:0]  off;
    logic [63:0] bit_len;
    logic [7:0]  pad_byte, byte_in;

    assign accept    = s_valid & s_ready;
    assign off       = {hw_idx, sel};
    assign bit_len   = 64'(byte_cnt) << 3;
    assign got_byte  = (state == S_COLLECT) && (last_seen || accept);
    assign issue_go  = (state == S_ISSUE) && !core_busy && (gap == '0);
    assign flush_go  = (state == S_FLUSH) && !core_busy && (gap == '0);
    assign fetch_go  = (state == S_FETCH) && (gap == '0);
    assign ack_load  = (state == S_WAIT_ACK) && ack;
    assign ack_fetch = (state == S_FETCH_ACK) && ack;
    assign final_blk = len_blk && (hw_idx == 5'd31);
    assign idle      = (state == S_IDLE);

    // Offsets 56..63 map to length bytes 0..7, MSB first; ~off[2:0] picks the byte lane.
    always_comb begin
        pad_byte = 8'h00;
        if (!sent80)
            pad_byte = 8'h80;
        else if (len_blk && off >= 6'd56)
            pad_byte = bit_len[{~off[2:0], 3'b000} +: 8];
    end

    assign byte_in = last_seen ? pad_byte : s_data;

    always_comb begin
        state_next = state;
        load_next  = 1'b0;
        fetch_next = 1'b0;
        dv_next    = 1'b0;
        case (state)
            S_IDLE:      if (accept) state_next = S_COLLECT;
            S_COLLECT:   if (got_byte && sel) state_next = S_ISSUE;
            S_ISSUE: begin
                if (issue_go) begin
                    load_next  = 1'b1;
                    state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK:  if (ack) state_next = final_blk ? S_FLUSH : S_COLLECT;
            S_FLUSH:     if (flush_go) state_next = S_FETCH;
            S_FETCH: begin
                if (fetch_go) begin
                    fetch_next = 1'b1;
                    state_next = S_FETCH_ACK;
                end
            end
            S_FETCH_ACK: if (ack) state_next = (dig_idx == 4'd15) ? S_DONE : S_FETCH;
            S_DONE: begin
                dv_next    = 1'b1;
                state_next = S_IDLE;
            end
            default:     state_next = S_IDLE;
        endcase

        // s_ready is registered, so it is derived from where the FSM lands next.
        last_next = last_seen;
        if (state == S_IDLE && accept)
            last_next = s_last;
        else if (state == S_COLLECT && accept)
            last_next = last_seen | s_last;
        ready_next = (state_next == S_IDLE) || (state_next == S_COLLECT && !last_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready      <= 1'b0;
            load         <= 1'b0;
            fetch        <= 1'b0;
            digest_valid <= 1'b0;
            wdata        <= '0;
            digest       <= '0;
            shadow       <= '0;
            byte_cnt     <= '0;
            hw_idx       <= '0;
            sel          <= 1'b0;
            hi_byte      <= '0;
            last_seen    <= 1'b0;
            sent80       <= 1'b0;
            len_blk      <= 1'b0;
            gap          <= '0;
            dig_idx      <= '0;
        end else begin
            s_ready      <= ready_next;
            load         <= load_next;
            fetch        <= fetch_next;
            digest_valid <= dv_next;

            if (state == S_IDLE && accept) begin
                hi_byte   <= s_data;
                sel       <= 1'b1;
                hw_idx    <= '0;
                byte_cnt  <= LEN_W'(1);
                last_seen <= s_last;
                sent80    <= 1'b0;
                len_blk   <= 1'b0;
            end

            if (got_byte) begin
                if (!last_seen) begin
                    if (byte_cnt != '1)
                        byte_cnt <= byte_cnt + LEN_W'(1);
                    last_seen <= s_last;
                end else if (!sent80) begin
                    sent80  <= 1'b1;
                    len_blk <= (off <= 6'd55);
                end
                if (!sel) begin
                    hi_byte <= byte_in;
                    sel     <= 1'b1;
                end else begin
                    wdata <= {hi_byte, byte_in};
                    sel   <= 1'b0;
                end
            end

            if (ack_load) begin
                hw_idx <= hw_idx + 5'd1;
                // Marker landed too late for the length: it goes in the next block.
                if (hw_idx == 5'd31 && sent80 && !len_blk)
                    len_blk <= 1'b1;
            end

            if (ack_load || ack_fetch)
                gap <= GAP_LOAD;
            else if (gap != '0)
                gap <= gap - GAP_W'(1);

            if (flush_go)
                dig_idx <= '0;

            if (ack_fetch) begin
                shadow[{~dig_idx, 4'b0000} +: 16] <= rdata;
                dig_idx <= dig_idx + 4'd1;
            end

            if (state == S_DONE)
                digest <= shadow;
        end
    end

endmodule

// File: tb/tb_sha256_pad_feeder.sv
module tb_sha256_pad_feeder;

    localparam int GAP = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic         s_ready;
    logic         load;
    logic         fetch;
    logic [15:0]  wdata;
    logic         ack = 1'b0;
    logic [15:0]  rdata = '0;
    logic         core_busy = 1'b0;
    logic [255:0] digest;
    logic         digest_valid;
    logic         idle;

    always #5 clk = ~clk;

    sha256_pad_feeder #(.LEN_W(32), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .load(load), .fetch(fetch), .wdata(wdata), .ack(ack), .rdata(rdata),
        .core_busy(core_busy), .digest(digest), .digest_valid(digest_valid), .idle(idle)
    );

    logic [255:0] ref_dig = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]   msg[$];
    logic [15:0]  loads[$];
    logic [255:0] dig_cap = '0;
    int nfetch, dv_cnt, viol, wviol, gviol, bviol;
    int ack_dly = 0, busy_hold = 0;
    int min_gap, last_load_cyc;
    int cyc = 0, last_ack_cyc = -100;

    // Interface model: acks each pulse after ack_dly cycles, records loads,
    // answers fetches with the reference digest and optionally raises core_busy.
    initial begin : responder
        bit pending = 0, is_f = 0, b_seen;
        int cnt = 0, bcnt = 0;
        logic [15:0] held = '0;
        forever begin
            @(negedge clk);
            cyc++;
            b_seen = core_busy;
            ack = 1'b0;
            if (!rst_n) begin
                pending = 0;
                core_busy = 1'b0;
                bcnt = 0;
            end else begin
                if (bcnt > 0) begin
                    bcnt--;
                    if (bcnt == 0) core_busy = 1'b0;
                end
                if (load && fetch) viol++;
                if (load || fetch) begin
                    if (pending) viol++;
                    if (cyc - last_ack_cyc < GAP + 1) gviol++;
                    if (load && b_seen) bviol++;
                    pending = 1;
                    cnt = ack_dly;
                    is_f = fetch;
                    if (load) begin
                        loads.push_back(wdata);
                        held = wdata;
                        if (last_load_cyc >= 0 && cyc - last_load_cyc < min_gap)
                            min_gap = cyc - last_load_cyc;
                        last_load_cyc = cyc;
                        if (busy_hold > 0) begin
                            core_busy = 1'b1;
                            bcnt = busy_hold;
                        end
                    end else begin
                        nfetch++;
                    end
                end else if (pending && !is_f && wdata !== held) begin
                    wviol++;
                end
                if (pending) begin
                    if (cnt == 0) begin
                        ack = 1'b1;
                        pending = 0;
                        last_ack_cyc = cyc;
                        if (is_f) rdata = ref_dig[255 - 16*(nfetch-1) -: 16];
                    end else begin
                        cnt--;
                    end
                end
                if (digest_valid) begin
                    dv_cnt++;
                    dig_cap = digest;
                end
            end
        end
    end

    task automatic clr();
        loads.delete();
        nfetch = 0; dv_cnt = 0; viol = 0; wviol = 0; gviol = 0; bviol = 0;
        min_gap = 1000000; last_load_cyc = -1;
    endtask

    task automatic send_msg(input bit gaps);
        int w;
        for (int i = 0; i < msg.size(); i++) begin
            if (gaps && i > 0) begin
                s_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
            s_data = msg[i];
            s_valid = 1'b1;
            s_last = (i == msg.size() - 1);
            w = 0;
            while (!s_ready && w < 5000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 5000) chk("s_ready_timeout", 256'(w), 256'(0));
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic fill_msg(input int n, input logic [7:0] b);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(b);
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    endtask

    task automatic wait_done(input string tag);
        int w = 0;
        while (dv_cnt == 0 && w < 20000) begin
            @(negedge clk);
            w++;
        end
        repeat (10) @(negedge clk);
        chk({tag, "_dv_count"}, 256'(dv_cnt), 256'(1));
        chk({tag, "_idle"}, 256'(idle), 256'(1));
    endtask

    task automatic check_abc_loads(input string tag);
        logic [15:0] e;
        chk({tag, "_nloads"}, 256'(loads.size()), 256'(32));
        for (int i = 0; i < 32 && i < loads.size(); i++) begin
            case (i)
                0:       e = 16'h6162;
                1:       e = 16'h6380;
                31:      e = 16'h0018;
                default: e = 16'h0000;
            endcase
            chk($sformatf("%s_hw%0d", tag, i), 256'(loads[i]), 256'(e));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 256'(s_ready), 256'(0));
        chk({tag, "_load"}, 256'(load), 256'(0));
        chk({tag, "_fetch"}, 256'(fetch), 256'(0));
        chk({tag, "_wdata"}, 256'(wdata), 256'(0));
        chk({tag, "_digest"}, digest, 256'(0));
        chk({tag, "_digest_valid"}, 256'(digest_valid), 256'(0));
        chk({tag, "_idle"}, 256'(idle), 256'(1));
    endtask

    initial begin
        int w;
        clr();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // "abc", immediate acks
        clr(); set_abc(); send_msg(0); wait_done("abc");
        check_abc_loads("abc");
        chk("abc_digest", dig_cap, ref_dig);
        chk("abc_nfetch", 256'(nfetch), 256'(16));
        chk("abc_proto", 256'(viol), 256'(0));
        chk("abc_gap", 256'(gviol), 256'(0));

        // 55 bytes: marker at offset 55, length fits in the same block
        clr(); fill_msg(55, 8'h41); send_msg(0); wait_done("m55");
        chk("m55_nloads", 256'(loads.size()), 256'(32));
        if (loads.size() == 32) begin
            chk("m55_hw0", 256'(loads[0]), 256'(16'h4141));
            chk("m55_hw27", 256'(loads[27]), 256'(16'h4180));
            chk("m55_hw28", 256'(loads[28]), 256'(0));
            chk("m55_hw29", 256'(loads[29]), 256'(0));
            chk("m55_hw30", 256'(loads[30]), 256'(0));
            chk("m55_hw31", 256'(loads[31]), 256'(16'h01b8));
        end

        // 56 bytes: marker at offset 56, length spills into a second block
        clr(); fill_msg(56, 8'h41); send_msg(0); wait_done("m56");
        chk("m56_nloads", 256'(loads.size()), 256'(64));
        if (loads.size() == 64) begin
            chk("m56_hw27", 256'(loads[27]), 256'(16'h4141));
            chk("m56_hw28", 256'(loads[28]), 256'(16'h8000));
            chk("m56_hw31", 256'(loads[31]), 256'(0));
            for (int i = 32; i < 63; i++)
                chk($sformatf("m56_hw%0d", i), 256'(loads[i]), 256'(0));
            chk("m56_hw63", 256'(loads[63]), 256'(16'h01c0));
        end

        // Odd length with s_valid gaps, core busy for 50 cycles after every load
        clr(); busy_hold = 50; ack_dly = 2;
        set_abc(); send_msg(1); wait_done("busy");
        busy_hold = 0;
        check_abc_loads("busy");
        chk("busy_min_gap_ok", 256'(min_gap >= 51), 256'(1));
        chk("busy_load_while_busy", 256'(bviol), 256'(0));
        chk("busy_wdata_stable", 256'(wviol), 256'(0));
        chk("busy_digest", dig_cap, ref_dig);

        // Slow acks on both loads and fetches
        clr(); ack_dly = 10;
        set_abc(); send_msg(0); wait_done("slow");
        chk("slow_nloads", 256'(loads.size()), 256'(32));
        chk("slow_nfetch", 256'(nfetch), 256'(16));
        chk("slow_proto", 256'(viol), 256'(0));
        chk("slow_wdata_stable", 256'(wviol), 256'(0));
        chk("slow_gap", 256'(gviol), 256'(0));
        chk("slow_digest", dig_cap, ref_dig);

        // Reset during the 10th load, then a fresh message
        clr(); set_abc(); send_msg(0);
        w = 0;
        while (loads.size() < 10 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("abort_reached_10th_load", 256'(loads.size() >= 10), 256'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_dv", 256'(dv_cnt), 256'(0));
        chk("abort_idle", 256'(idle), 256'(1));

        clr(); ack_dly = 1;
        set_abc(); send_msg(0); wait_done("fresh");
        check_abc_loads("fresh");
        chk("fresh_digest", dig_cap, ref_dig);
        chk("fresh_digest_held", digest, ref_dig);
        chk("fresh_proto", 256'(viol), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
